dest_reg_pipe: RTL and testbench
================================

// Module: dest_reg_pipe
// PURPOSE
//  Parametrised destination-register selector for the pipelined datapath.
//  Picks the write-back register (rd, rt or link register for JAL) in decode,
//  then carries it with its write-enable through STAGES pipeline slots
//  (EX/MEM/WB by default). Compares source registers against in-flight
//  destinations to drive hazard detection and forwarding select.
// PARAMETERS
//  REG_AW    5   register-number width
//  STAGES    3   in-flight slots tracked (slot 0 = EX, slot STAGES-1 = WB)
//  LINK_REG  31  destination forced when jal=1
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous reset, active-high
//  rt         in   REG_AW          instruction rt field
//  rd         in   REG_AW          instruction rd field
//  regrt      in   1               1: destination = rt, 0: destination = rd
//  jal        in   1               1: destination = LINK_REG (overrides regrt)
//  wreg       in   1               decoded instruction writes a register
//  stall      in   1               hold slot 0, insert bubble into slot 1
//  flush      in   1               kill instruction entering slot 0
//  rs_q       in   REG_AW          decode-stage rs to check
//  rt_q       in   REG_AW          decode-stage rt to check
//  nd         out  REG_AW          selected destination (combinational)
//  slot_nd    out  STAGES*REG_AW   slot k at bits [k*REG_AW +: REG_AW]
//  slot_wr    out  STAGES          slot k valid-write flag
//  hazard_rs  out  1               rs_q matches a valid in-flight write
//  hazard_rt  out  1               rt_q matches a valid in-flight write
//  fwd_rs     out  $clog2(STAGES+1) 0 = no match, k+1 = youngest match slot k
//  fwd_rt     out  $clog2(STAGES+1) as fwd_rs for rt_q
//  hazard_cnt out  16              hazard-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Select: nd = jal ? LINK_REG : (regrt ? rt : rd). Pure combinational, no latency.
//  - Write flag into slot 0: wr0 = wreg & (nd != 0); writes to r0 never tracked.
//  - Reset (async, rst=1): all slot_nd = 0, slot_wr = 0, hazard_cnt = 0;
//    thus hazard_* = 0, fwd_* = 0. Reset mid-operation drops all in-flight entries.
//  - Each clk edge, priority flush > stall > normal for slot 0:
//    flush: slot 0 <= {nd=0, wr=0}; slots 1..STAGES-1 shift normally.
//    stall: slot 0 holds; slot 1 <= bubble {0,0}; slots 2.. shift normally.
//    normal: slot 0 <= {nd, wr0}; slot k <= slot k-1 for k>=1.
//  - Slot STAGES-1 contents are discarded on shift (retire, no wrap).
//  - Compare (combinational): match_k = slot_wr[k] & (slot_nd[k] == q) & (q != 0).
//    hazard_* = OR of match_k; fwd_* = k+1 for lowest k matching (youngest wins
//    when several slots hold the same register).
//  - stall & flush together: flush wins, slot 1 still shifts from slot 0.
//  - STAGES == 1: stall simply holds slot 0 (no slot 1 to bubble).
// CONFIGURATION
//  HAZARD_COUNT_EN defined: hazard_cnt increments on each clk where
//    (hazard_rs | hazard_rt) = 1; saturates at 16'hFFFF; cleared by rst only.
//  HAZARD_COUNT_EN undefined: counter logic omitted; hazard_cnt tied to 16'h0000.
// TESTING
//  1. regrt=0,jal=0,rd=5,rt=9 -> nd=5; regrt=1 -> nd=9; jal=1,regrt=0 -> nd=31.
//  2. wreg=1,nd=8 issued one cycle; next 3 edges -> slot 0,1,2 each hold 8 in turn,
//     rs_q=8 gives fwd_rs=1,2,3 per cycle, then hazard_rs=0 after retire.
//  3. rd=0,wreg=1,regrt=0 -> slot_wr[0]=0 after edge; rs_q=0 -> hazard_rs=0.
//  4. slot0 nd=4, assert stall one cycle -> slot0 stays 4, slot1 = {0,0};
//     stall+flush same cycle -> slot0 = {0,0}, slot1 = previous slot0.
//  5. slots 0 and 2 both write r7, rt_q=7 -> hazard_rt=1, fwd_rt=1; assert rst
//     mid-stream -> all slot_wr=0, fwd_rt=0 without waiting for clk.
//  6. HAZARD_COUNT_EN defined: 10 hazard cycles -> hazard_cnt=10; force 70000
//     -> holds 16'hFFFF; undefined build -> hazard_cnt=0 throughout.

Source files
------------

// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe: destination-register selector and in-flight destination tracker.
//   Selects the write-back register (rd, rt or LINK_REG for jal) in decode.
//   It carries that register and its write flag through STAGES slots
//   (slot 0 = EX ... slot STAGES-1 = WB).
//   It compares decode-stage rs/rt against the in-flight writes for hazard
//   detection and forwarding select.
// Optional feature macro: HAZARD_COUNT_EN
//   defined   -> saturating 16-bit count of hazard cycles on hazard_cnt
//   undefined -> hazard_cnt tied to zero
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rt, rd, regrt, jal  destination select inputs
//   wreg                decoded instruction writes a register
//   stall, flush        slot-0 hold / kill controls (flush has priority)
//   rs_q, rt_q          decode-stage source registers to check
//   nd                  selected destination (combinational)
//   slot_nd, slot_wr    in-flight destinations and write flags, slot k at k*REG_AW
//   hazard_rs/rt        source matches a valid in-flight write (combinational)
//   fwd_rs/rt           0 = no match, k+1 = youngest matching slot k (combinational)
//   hazard_cnt          hazard-cycle counter
module dest_reg_pipe #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned LINK_REG = 31
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REG_AW-1:0]             rt,
    input  logic [REG_AW-1:0]             rd,
    input  logic                          regrt,
    input  logic                          jal,
    input  logic                          wreg,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [REG_AW-1:0]             rs_q,
    input  logic [REG_AW-1:0]             rt_q,
    output logic [REG_AW-1:0]             nd,
    output logic [STAGES*REG_AW-1:0]      slot_nd,
    output logic [STAGES-1:0]             slot_wr,
    output logic                          hazard_rs,
    output logic                          hazard_rt,
    output logic [$clog2(STAGES+1)-1:0]   fwd_rs,
    output logic [$clog2(STAGES+1)-1:0]   fwd_rt,
    output logic [15:0]                   hazard_cnt
);

    localparam int unsigned FW_W  = $clog2(STAGES + 1);
    localparam int unsigned CNT_W = 16;

    logic [STAGES-1:0][REG_AW-1:0] slot_nd_q, slot_nd_d;
    logic [STAGES-1:0]             slot_wr_q, slot_wr_d;
    logic                          wr0;

    // Destination select; jal overrides regrt.
    always_comb begin
        nd  = jal ? REG_AW'(LINK_REG) : (regrt ? rt : rd);
        wr0 = wreg & (nd != '0);
    end

    // Slot next-state: flush > stall > normal for slot 0.
    always_comb begin
        slot_nd_d = slot_nd_q;
        slot_wr_d = slot_wr_q;
        for (int k = 1; k < STAGES; k++) begin
            if (k == 1 && stall && !flush) begin
                // Stalled slot 0 stays put, so a bubble enters slot 1.
                slot_nd_d[k] = '0;
                slot_wr_d[k] = 1'b0;
            end else begin
                slot_nd_d[k] = slot_nd_q[k-1];
                slot_wr_d[k] = slot_wr_q[k-1];
            end
        end
        if (flush) begin
            slot_nd_d[0] = '0;
            slot_wr_d[0] = 1'b0;
        end else if (!stall) begin
            slot_nd_d[0] = nd;
            slot_wr_d[0] = wr0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_nd_q <= '0;
            slot_wr_q <= '0;
        end else begin
            slot_nd_q <= slot_nd_d;
            slot_wr_q <= slot_wr_d;
        end
    end

    assign slot_nd = slot_nd_q;
    assign slot_wr = slot_wr_q;

    // Source compare; scanning oldest to youngest lets the youngest match win.
    always_comb begin
        hazard_rs = 1'b0;
        hazard_rt = 1'b0;
        fwd_rs    = '0;
        fwd_rt    = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (slot_wr_q[k] && (slot_nd_q[k] == rs_q) && (rs_q != '0)) begin
                hazard_rs = 1'b1;
                fwd_rs    = FW_W'(k + 1);
            end
            if (slot_wr_q[k] && (slot_nd_q[k] == rt_q) && (rt_q != '0)) begin
                hazard_rt = 1'b1;
                fwd_rt    = FW_W'(k + 1);
            end
        end
    end

`ifdef HAZARD_COUNT_EN
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

    // Saturating hazard-cycle counter.
    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if ((hazard_rs || hazard_rt) && (hazard_cnt_q != {CNT_W{1'b1}})) begin
            hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_cnt_q <= '0;
        end else begin
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign hazard_cnt = hazard_cnt_q;
`else
    assign hazard_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed testbench for dest_reg_pipe (default parameters: REG_AW=5, STAGES=3).
module tb_dest_reg_pipe;

    logic        clk;
    logic        rst;
    logic [4:0]  rt, rd, rs_q, rt_q;
    logic        regrt, jal, wreg, stall, flush;
    logic [4:0]  nd;
    logic [14:0] slot_nd;
    logic [2:0]  slot_wr;
    logic        hazard_rs, hazard_rt;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [15:0] hazard_cnt;

    int checks = 0;
    int errors = 0;

    dest_reg_pipe #(.REG_AW(5), .STAGES(3), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .rt(rt), .rd(rd), .regrt(regrt), .jal(jal),
        .wreg(wreg), .stall(stall), .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
        .nd(nd), .slot_nd(slot_nd), .slot_wr(slot_wr),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .hazard_cnt(hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        wreg = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rt = 5'd0; rd = 5'd0; regrt = 1'b0; jal = 1'b0; wreg = 1'b0;
        stall = 1'b0; flush = 1'b0; rs_q = 5'd0; rt_q = 5'd0;
        #22;
        checks++; if (slot_wr !== 3'b000) begin errors++; $display("FAIL reset_slot_wr got=%b exp=000", slot_wr); end
        checks++; if (slot_nd !== 15'd0) begin errors++; $display("FAIL reset_slot_nd got=%h exp=0", slot_nd); end
        checks++; if (hazard_cnt !== 16'd0) begin errors++; $display("FAIL reset_hazard_cnt got=%0d exp=0", hazard_cnt); end
        rs_q = 5'd7; #1;
        checks++; if (hazard_rs !== 1'b0 || fwd_rs !== 2'd0) begin errors++; $display("FAIL reset_hazard got=%b/%0d exp=0/0", hazard_rs, fwd_rs); end
        rs_q = 5'd0;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_select();
        rd = 5'd5; rt = 5'd9; regrt = 1'b0; jal = 1'b0; #1;
        checks++; if (nd !== 5'd5) begin errors++; $display("FAIL sel_rd got=%0d exp=5", nd); end
        regrt = 1'b1; #1;
        checks++; if (nd !== 5'd9) begin errors++; $display("FAIL sel_rt got=%0d exp=9", nd); end
        regrt = 1'b0; jal = 1'b1; #1;
        checks++; if (nd !== 5'd31) begin errors++; $display("FAIL sel_jal got=%0d exp=31", nd); end
        regrt = 1'b1; #1;
        checks++; if (nd !== 5'd31) begin errors++; $display("FAIL sel_jal_regrt got=%0d exp=31", nd); end
        jal = 1'b0; regrt = 1'b0;
    endtask

    task automatic test_pipeline();
        rd = 5'd8; wreg = 1'b1; rs_q = 5'd8;
        step();
        wreg = 1'b0; rd = 5'd0; #1;
        checks++; if (slot_nd[4:0] !== 5'd8 || slot_wr !== 3'b001) begin errors++; $display("FAIL pipe_slot0 got=%0d/%b exp=8/001", slot_nd[4:0], slot_wr); end
        checks++; if (fwd_rs !== 2'd1 || hazard_rs !== 1'b1) begin errors++; $display("FAIL pipe_fwd1 got=%0d/%b exp=1/1", fwd_rs, hazard_rs); end
        step();
        checks++; if (slot_nd[9:5] !== 5'd8 || slot_wr !== 3'b010) begin errors++; $display("FAIL pipe_slot1 got=%0d/%b exp=8/010", slot_nd[9:5], slot_wr); end
        checks++; if (fwd_rs !== 2'd2) begin errors++; $display("FAIL pipe_fwd2 got=%0d exp=2", fwd_rs); end
        step();
        checks++; if (slot_nd[14:10] !== 5'd8 || slot_wr !== 3'b100) begin errors++; $display("FAIL pipe_slot2 got=%0d/%b exp=8/100", slot_nd[14:10], slot_wr); end
        checks++; if (fwd_rs !== 2'd3) begin errors++; $display("FAIL pipe_fwd3 got=%0d exp=3", fwd_rs); end
        step();
        checks++; if (hazard_rs !== 1'b0 || fwd_rs !== 2'd0 || slot_wr !== 3'b000) begin errors++; $display("FAIL pipe_retire got=%b/%0d/%b exp=0/0/000", hazard_rs, fwd_rs, slot_wr); end
        rs_q = 5'd0;
    endtask

    task automatic test_r0();
        rd = 5'd0; regrt = 1'b0; wreg = 1'b1;
        step();
        wreg = 1'b0; rs_q = 5'd0; rt_q = 5'd0; #1;
        checks++; if (slot_wr[0] !== 1'b0) begin errors++; $display("FAIL r0_wr got=%b exp=0", slot_wr[0]); end
        checks++; if (hazard_rs !== 1'b0 || hazard_rt !== 1'b0) begin errors++; $display("FAIL r0_hazard got=%b%b exp=00", hazard_rs, hazard_rt); end
    endtask

    task automatic test_stall_flush();
        drain();
        rd = 5'd4; wreg = 1'b1;
        step();
        stall = 1'b1; rd = 5'd6;
        step();
        checks++; if (slot_nd !== {5'd0, 5'd0, 5'd4} || slot_wr !== 3'b001) begin errors++; $display("FAIL stall_hold got=%h/%b exp=%h/001", slot_nd, slot_wr, {5'd0, 5'd0, 5'd4}); end
        flush = 1'b1;
        step();
        checks++; if (slot_nd !== {5'd0, 5'd4, 5'd0} || slot_wr !== 3'b010) begin errors++; $display("FAIL stall_flush got=%h/%b exp=%h/010", slot_nd, slot_wr, {5'd0, 5'd4, 5'd0}); end
        stall = 1'b0; rd = 5'd12;
        step();
        flush = 1'b0; wreg = 1'b0; rs_q = 5'd4; #1;
        checks++; if (slot_nd !== {5'd4, 5'd0, 5'd0} || slot_wr !== 3'b100) begin errors++; $display("FAIL flush_only got=%h/%b exp=%h/100", slot_nd, slot_wr, {5'd4, 5'd0, 5'd0}); end
        checks++; if (fwd_rs !== 2'd3) begin errors++; $display("FAIL flush_fwd got=%0d exp=3", fwd_rs); end
        rs_q = 5'd0;
    endtask

    task automatic test_multi_match();
        drain();
        wreg = 1'b1; rd = 5'd7;
        step();
        rd = 5'd3;
        step();
        rd = 5'd7;
        step();
        wreg = 1'b0; rt_q = 5'd7; rs_q = 5'd3; #1;
        checks++; if (hazard_rt !== 1'b1 || fwd_rt !== 2'd1) begin errors++; $display("FAIL multi_rt got=%b/%0d exp=1/1", hazard_rt, fwd_rt); end
        checks++; if (hazard_rs !== 1'b1 || fwd_rs !== 2'd2) begin errors++; $display("FAIL multi_rs got=%b/%0d exp=1/2", hazard_rs, fwd_rs); end
        rst = 1'b1; #1;
        checks++; if (slot_wr !== 3'b000 || fwd_rt !== 2'd0 || hazard_rt !== 1'b0) begin errors++; $display("FAIL async_rst got=%b/%0d/%b exp=000/0/0", slot_wr, fwd_rt, hazard_rt); end
        @(negedge clk);
        rst = 1'b0; rs_q = 5'd0; rt_q = 5'd0;
        step();
    endtask

    task automatic test_hazard_cnt();
        logic [15:0] exp_cnt;
        checks++; if (hazard_cnt !== 16'd0) begin errors++; $display("FAIL cnt_start got=%0d exp=0", hazard_cnt); end
        wreg = 1'b1; rd = 5'd10; rs_q = 5'd10;
        for (int i = 0; i < 11; i++) step();
        wreg = 1'b0; rs_q = 5'd0;
        step();
`ifdef HAZARD_COUNT_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        checks++; if (hazard_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_ten got=%0d exp=%0d", hazard_cnt, exp_cnt); end
        wreg = 1'b1; rs_q = 5'd10;
`ifdef HAZARD_COUNT_EN
        for (int i = 0; i < 65600; i++) step();
        exp_cnt = 16'hFFFF;
`else
        for (int i = 0; i < 200; i++) step();
        exp_cnt = 16'd0;
`endif
        checks++; if (hazard_rs !== 1'b1) begin errors++; $display("FAIL cnt_hazard got=%b exp=1", hazard_rs); end
        checks++; if (hazard_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_sat got=%h exp=%h", hazard_cnt, exp_cnt); end
        step();
        checks++; if (hazard_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_hold got=%h exp=%h", hazard_cnt, exp_cnt); end
        wreg = 1'b0; rs_q = 5'd0;
    endtask

    initial begin
        test_reset();
        test_select();
        test_pipeline();
        test_r0();
        test_stall_flush();
        test_multi_match();
        test_hazard_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
